// File: rtl/nat_pkg.sv
// rtl/nat_pkg.sv - shared constants, FSM state type and tuple field offsets for the NAT connection table
package nat_pkg;

  localparam int NAT_ID_BITS = 6;
  localparam int NAT_KEY_W   = 104;
  localparam int TUPLE_W     = 128;

  // Field offsets within the 128-bit parser tuple
  localparam int PROTO_LSB = 0;   // [7:0]
  localparam int DPORT_LSB = 8;   // [23:8]
  localparam int SPORT_LSB = 24;  // [39:24]
  localparam int DIP_LSB   = 40;  // [71:40]
  localparam int SIP_LSB   = 72;  // [103:72]

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HASH,
    ST_PROBE,
    ST_RESP,
    ST_DONE
  } nat_state_e;

endpackage

// File: rtl/nat_conn_table_if.sv
// rtl/nat_conn_table_if.sv - parser <-> connection table request/response bundle
// Signals:
//   tuple_data_i  : 128-bit 5-tuple from the parser
//   tuple_valid_i : request level, held until conn_valid_o is seen
//   conn_data_o   : {full, zeros, connection ID}
//   conn_valid_o  : single-cycle response pulse
//   conn_count_o  : occupied entry count
//   table_full_o  : all entries occupied
// master = parser side, slave = connection table side.
interface nat_conn_table_if
  import nat_pkg::*;
#(
  parameter int ID_BITS = NAT_ID_BITS
);
  logic [TUPLE_W-1:0] tuple_data_i;
  logic               tuple_valid_i;
  logic [15:0]        conn_data_o;
  logic               conn_valid_o;
  logic [ID_BITS:0]   conn_count_o;
  logic               table_full_o;

  modport master (
    output tuple_data_i, tuple_valid_i,
    input  conn_data_o, conn_valid_o, conn_count_o, table_full_o
  );

  modport slave (
    input  tuple_data_i, tuple_valid_i,
    output conn_data_o, conn_valid_o, conn_count_o, table_full_o
  );
endinterface

// File: rtl/nat_tuple_fold.sv
// rtl/nat_tuple_fold.sv - XOR-fold of the connection key down to a table start index
// Ports:
//   key   : KEY_W-bit connection key
//   index : ID_BITS-bit XOR of all ID_BITS-wide key slices (top slice zero-padded)
module nat_tuple_fold
  import nat_pkg::*;
#(
  parameter int KEY_W   = NAT_KEY_W,
  parameter int ID_BITS = NAT_ID_BITS
) (
  input  logic [KEY_W-1:0]   key,
  output logic [ID_BITS-1:0] index
);

  localparam int NSLICES = (KEY_W + ID_BITS - 1) / ID_BITS;
  localparam int PAD_W   = NSLICES * ID_BITS;

  logic [PAD_W-1:0] padded;

  always_comb begin
    padded = PAD_W'(key);
    index  = '0;
    for (int s = 0; s < NSLICES; s++) begin
      index = index ^ padded[s*ID_BITS +: ID_BITS];
    end
  end

endmodule

// File: rtl/nat_conn_table.sv
// rtl/nat_conn_table.sv - linear-probing connection table returning a connection ID per tuple
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : nat_conn_table_if.slave (tuple request in, connection response out)
// A miss inserts the key; a fully probed table answers ID 0 with the full flag.
module nat_conn_table
  import nat_pkg::*;
#(
  parameter int ID_BITS = NAT_ID_BITS,
  parameter int KEY_W   = NAT_KEY_W
) (
  input logic             clk,
  input logic             reset,
  nat_conn_table_if.slave bus
);

  localparam int DEPTH = 1 << ID_BITS;

  nat_state_e         state, state_next;
  logic [KEY_W-1:0]   key_q;
  logic [ID_BITS-1:0] index_q;
  logic [ID_BITS-1:0] probe_cnt_q;
  logic [ID_BITS-1:0] fold_idx;
  logic [DEPTH-1:0]   valid_q;
  logic [KEY_W-1:0]   key_mem [DEPTH];
  logic [ID_BITS:0]   count_q;
  logic [15:0]        conn_data_q;

  logic entry_hit, entry_empty, probe_last;
  logic latch_req, resolve, do_insert;
  logic unused_tuple_hi;

  assign unused_tuple_hi = ^bus.tuple_data_i[TUPLE_W-1:KEY_W];

  nat_tuple_fold #(.KEY_W(KEY_W), .ID_BITS(ID_BITS)) u_fold (
    .key   (key_q),
    .index (fold_idx)
  );

  assign entry_hit   = valid_q[index_q] && (key_mem[index_q] == key_q);
  assign entry_empty = !valid_q[index_q];
  // Last of DEPTH probes: a collision here means every slot was examined
  assign probe_last  = (probe_cnt_q == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_req  = 1'b0;
    resolve    = 1'b0;
    do_insert  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.tuple_valid_i) begin
          latch_req  = 1'b1;
          state_next = ST_HASH;
        end
      end
      ST_HASH:  state_next = ST_PROBE;
      ST_PROBE: begin
        if (entry_hit || entry_empty || probe_last) begin
          resolve    = 1'b1;
          do_insert  = entry_empty;
          state_next = ST_RESP;
        end
      end
      ST_RESP:  state_next = ST_DONE;
      // Hold here until the parser drops its level so it cannot re-trigger
      ST_DONE:  if (!bus.tuple_valid_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q       <= '0;
      index_q     <= '0;
      probe_cnt_q <= '0;
      valid_q     <= '0;
      count_q     <= '0;
      conn_data_q <= '0;
    end else begin
      if (latch_req) begin
        key_q       <= bus.tuple_data_i[KEY_W-1:0];
        probe_cnt_q <= '0;
      end
      if (state == ST_HASH) index_q <= fold_idx;
      if (state == ST_PROBE && !resolve) begin
        index_q     <= index_q + 1'b1;
        probe_cnt_q <= probe_cnt_q + 1'b1;
      end
      if (resolve) begin
        conn_data_q <= (entry_hit || entry_empty) ? 16'(index_q) : 16'h8000;
      end
      if (do_insert) begin
        valid_q[index_q] <= 1'b1;
        count_q          <= count_q + 1'b1;
      end
    end
  end

  // Keys carry no reset; the valid bits alone define occupancy
  always_ff @(posedge clk) begin
    if (do_insert) key_mem[index_q] <= key_q;
  end

  assign bus.conn_data_o  = conn_data_q;
  assign bus.conn_valid_o = (state == ST_RESP);
  assign bus.conn_count_o = count_q;
  assign bus.table_full_o = (count_q == (ID_BITS+1)'(DEPTH));

endmodule

// File: tb/tb_nat_conn_table.sv
// tb/tb_nat_conn_table.sv - randomized self-checking bench for nat_conn_table
module tb_nat_conn_table;
  import nat_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  nat_conn_table_if #(.ID_BITS(6)) bus();

  nat_conn_table #(.ID_BITS(6), .KEY_W(104)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference table: array of slots searched from the hash with wrap-around
  bit           m_valid [64];
  logic [103:0] m_key   [64];
  int           m_count = 0;
  logic [127:0] first_tuple;

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_count = 0;
  endfunction

  function automatic int model_hash(input logic [103:0] k);
    int h = 0;
    for (int s = 0; s < 18; s++) h = h ^ int'((k >> (6 * s)) & 104'h3F);
    return h;
  endfunction

  // Expected response and latency (negedges from request to pulse)
  function automatic void model_access(input logic [103:0] k, output logic [15:0] ed, output int el);
    int h = model_hash(k);
    for (int p = 0; p < 64; p++) begin
      int idx = (h + p) % 64;
      if (m_valid[idx] && m_key[idx] == k) begin
        ed = 16'(idx); el = p + 3; return;
      end
      if (!m_valid[idx]) begin
        m_valid[idx] = 1'b1; m_key[idx] = k; m_count++;
        ed = 16'(idx); el = p + 3; return;
      end
    end
    ed = 16'h8000;
    el = 66;
  endfunction

  function automatic logic [127:0] mk_tuple(input logic [31:0] sip, input logic [31:0] dip,
                                            input logic [15:0] sp, input logic [15:0] dp,
                                            input logic [7:0] pr);
    logic [127:0] t;
    t = '0;
    t[127:104]            = 24'($urandom());
    t[SIP_LSB   +: 32]    = sip;
    t[DIP_LSB   +: 32]    = dip;
    t[SPORT_LSB +: 16]    = sp;
    t[DPORT_LSB +: 16]    = dp;
    t[PROTO_LSB +: 8]     = pr;
    return t;
  endfunction

  function automatic logic [127:0] rand_tuple();
    return mk_tuple($urandom(), $urandom(), 16'($urandom()), 16'($urandom()), 8'($urandom()));
  endfunction

  // Drives one request, holds the level `hold` extra cycles after the pulse,
  // returns response, latency (-1 on timeout) and count of additional pulses.
  task automatic issue(input logic [127:0] t, input int hold,
                       output logic [15:0] d, output int l, output int extra,
                       output logic [15:0] ed, output int el);
    logic [103:0] k;
    k = t[103:0];
    model_access(k, ed, el);
    @(negedge clk);
    bus.tuple_data_i  = t;
    bus.tuple_valid_i = 1'b1;
    l = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.conn_valid_o) begin l = c; break; end
    end
    d = bus.conn_data_o;
    extra = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus.conn_valid_o) extra++;
    end
    bus.tuple_valid_i = 1'b0;
    bus.tuple_data_i  = rand_tuple();
    repeat (2) begin
      @(negedge clk);
      if (bus.conn_valid_o) extra++;
    end
  endtask

  task automatic test_reset();
    bus.tuple_valid_i = 1'b0;
    bus.tuple_data_i  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.conn_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.conn_valid_o); end
    checks++; if (bus.conn_data_o !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0000", bus.conn_data_o); end
    checks++; if (bus.conn_count_o !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.conn_count_o); end
    checks++; if (bus.table_full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.table_full_o); end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_first_and_repeat();
    logic [15:0] d, ed; int l, el, x;
    first_tuple = mk_tuple(0, 0, 0, 0, 8'h06);
    for (int r = 0; r < 2; r++) begin
      issue(first_tuple, 0, d, l, x, ed, el);
      checks++; if (d !== ed) begin errors++; $display("FAIL first_data[%0d] got %h exp %h", r, d, ed); end
      checks++; if (l !== el) begin errors++; $display("FAIL first_latency[%0d] got %0d exp %0d", r, l, el); end
      checks++; if (bus.conn_count_o !== 7'(m_count)) begin errors++; $display("FAIL first_count[%0d] got %0d exp %0d", r, bus.conn_count_o, m_count); end
      checks++; if (x !== 0) begin errors++; $display("FAIL first_pulses[%0d] got %0d extra exp 0", r, x); end
    end
  endtask

  task automatic test_collision();
    logic [15:0] d, ed; int l, el, x;
    issue(mk_tuple(0, 0, 0, 16'h0010, 8'h46), 0, d, l, x, ed, el);
    checks++; if (d !== ed) begin errors++; $display("FAIL coll_data got %h exp %h", d, ed); end
    checks++; if (l !== el) begin errors++; $display("FAIL coll_latency got %0d exp %0d", l, el); end
    checks++; if (bus.conn_count_o !== 7'(m_count)) begin errors++; $display("FAIL coll_count got %0d exp %0d", bus.conn_count_o, m_count); end
    checks++; if (bus.conn_data_o !== ed) begin errors++; $display("FAIL coll_hold got %h exp %h", bus.conn_data_o, ed); end
  endtask

  task automatic test_wrap();
    logic [15:0] d, ed; int l, el, x;
    issue(mk_tuple(0, 0, 0, 0, 8'h3F), 0, d, l, x, ed, el);
    checks++; if (d !== ed) begin errors++; $display("FAIL wrap_pre_data got %h exp %h", d, ed); end
    issue(mk_tuple(0, 0, 0, 16'h0010, 8'h7F), 0, d, l, x, ed, el);
    checks++; if (d !== ed) begin errors++; $display("FAIL wrap_data got %h exp %h", d, ed); end
    checks++; if (l !== el) begin errors++; $display("FAIL wrap_latency got %0d exp %0d", l, el); end
  endtask

  task automatic test_random();
    logic [15:0] d, ed; int l, el, x;
    logic [127:0] t, prev;
    prev = first_tuple;
    for (int i = 0; i < 10; i++) begin
      t = ($urandom_range(0, 3) == 0) ? prev : rand_tuple();
      prev = t;
      issue(t, $urandom_range(0, 3), d, l, x, ed, el);
      checks++; if (d !== ed) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, d, ed); end
      checks++; if (l !== el) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, l, el); end
      checks++; if (bus.conn_count_o !== 7'(m_count)) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", i, bus.conn_count_o, m_count); end
    end
  endtask

  task automatic test_stale();
    logic [15:0] d, ed; int l, el, x;
    issue(rand_tuple(), 10, d, l, x, ed, el);
    checks++; if (d !== ed) begin errors++; $display("FAIL stale_data got %h exp %h", d, ed); end
    checks++; if (x !== 0) begin errors++; $display("FAIL stale_pulses got %0d extra exp 0", x); end
    checks++; if (bus.conn_count_o !== 7'(m_count)) begin errors++; $display("FAIL stale_count got %0d exp %0d", bus.conn_count_o, m_count); end
  endtask

  task automatic test_full();
    logic [15:0] d, ed; int l, el, x;
    for (int i = 0; i < 200 && m_count < 64; i++) begin
      issue(rand_tuple(), 0, d, l, x, ed, el);
      checks++; if (d !== ed || l !== el) begin errors++; $display("FAIL fill[%0d] got %h/%0d exp %h/%0d", i, d, l, ed, el); end
    end
    checks++; if (bus.table_full_o !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", bus.table_full_o); end
    checks++; if (bus.conn_count_o !== 7'd64) begin errors++; $display("FAIL full_count got %0d exp 64", bus.conn_count_o); end
    issue(rand_tuple(), 0, d, l, x, ed, el);
    checks++; if (d !== ed) begin errors++; $display("FAIL full_new_data got %h exp %h", d, ed); end
    checks++; if (l !== el) begin errors++; $display("FAIL full_new_latency got %0d exp %0d", l, el); end
    checks++; if (bus.conn_count_o !== 7'd64) begin errors++; $display("FAIL full_new_count got %0d exp 64", bus.conn_count_o); end
    issue(first_tuple, 0, d, l, x, ed, el);
    checks++; if (d !== ed) begin errors++; $display("FAIL full_hit_data got %h exp %h", d, ed); end
    checks++; if (l !== el) begin errors++; $display("FAIL full_hit_latency got %0d exp %0d", l, el); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] d, ed; int l, el, x;
    logic [127:0] t;
    t = rand_tuple();
    @(negedge clk);
    bus.tuple_data_i  = t;
    bus.tuple_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.tuple_valid_i = 1'b0;
    #1;
    checks++; if (bus.conn_data_o !== 16'h0) begin errors++; $display("FAIL mreset_data got %h exp 0000", bus.conn_data_o); end
    checks++; if (bus.conn_count_o !== 7'd0) begin errors++; $display("FAIL mreset_count got %0d exp 0", bus.conn_count_o); end
    checks++; if (bus.table_full_o !== 1'b0) begin errors++; $display("FAIL mreset_full got %b exp 0", bus.table_full_o); end
    @(negedge clk);
    checks++; if (bus.conn_valid_o !== 1'b0) begin errors++; $display("FAIL mreset_valid got %b exp 0", bus.conn_valid_o); end
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++; if (bus.conn_valid_o !== 1'b0) begin errors++; $display("FAIL mreset_lost_resp got %b exp 0", bus.conn_valid_o); end
    issue(t, 0, d, l, x, ed, el);
    checks++; if (d !== ed || l !== el) begin errors++; $display("FAIL mreset_reissue got %h/%0d exp %h/%0d", d, l, ed, el); end
    checks++; if (bus.conn_count_o !== 7'(m_count)) begin errors++; $display("FAIL mreset_reissue_count got %0d exp %0d", bus.conn_count_o, m_count); end
  endtask

  initial begin
    test_reset();
    test_first_and_repeat();
    test_collision();
    test_wrap();
    test_random();
    test_stale();
    test_full();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nat_conn_table.md
# nat_conn_table

Connection-table stage paired with the packet parser in the NAT datapath. It consumes the 5-tuple the parser raises on its tuple request port, hashes it, and looks it up in an on-chip table using linear probing. A new tuple is inserted on a miss. The block returns the connection ID that the parser writes into the rewritten port field.

## Interface
- `ID_BITS`, default 6: connection-ID width; table depth is 2^ID_BITS; legal range 1..15 (the parser consumes at most 8).
- `KEY_W`, default 104: key width, equal to `tuple_data_i[103:0]` = {src_ip, dst_ip, src_port, dst_port, protocol}.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tuple_data_i`  in  128  tuple from the parser; bits [127:104] are ignored.
- `tuple_valid_i`  in  1  request level; the parser holds it high until it sees `conn_valid_o`.
- `conn_data_o`  out  16  response:
  - [ID_BITS-1:0] connection ID;
  - [14:ID_BITS] zero;
  - [15] full flag.
- `conn_valid_o`  out  1  single-cycle response pulse.
- `conn_count_o`  out  ID_BITS+1  number of occupied entries.
- `table_full_o`  out  1  high when `conn_count_o == 2^ID_BITS`.

## Operation
- Storage is 2^ID_BITS entries, each a valid bit plus a KEY_W-bit key. Valid bits are in flops cleared by reset; keys are not reset.
- Hash is an XOR-fold: key split into ID_BITS-wide slices from bit 0 upward, top slice zero-padded, all slices XORed.
- FSM states: IDLE, HASH, PROBE, RESP, DONE.
- **IDLE:** if `tuple_valid_i` is high, latch the key, set probe counter to 0, go to HASH.
- **HASH:** index <= fold(key); go to PROBE.
- **PROBE:** examine entry[index] once per cycle.
  - Valid and key equal (hit): ID = index; go to RESP.
  - Not valid (miss): write key, set valid, increment count, ID = index; go to RESP.
  - Otherwise (collision): index <= index+1, wrapping modulo 2^ID_BITS; probe counter +1.
  - Probe counter reaches 2^ID_BITS with no hit or empty entry (full): ID = 0, full flag = 1; go to RESP. Nothing is written.
- **RESP:** drive `conn_data_o`, pulse `conn_valid_o` for one cycle; go to DONE.
- **DONE:** wait until `tuple_valid_i` is low, then go to IDLE. This prevents a stale level from re-triggering a lookup.
- `tuple_valid_i` is ignored outside IDLE; the latched key is never overwritten mid-lookup.
- Entries are never deleted; only reset empties the table.
- `conn_data_o` holds its last value after the pulse. Its [15] bit is cleared on the next non-full response.

## Timing
- Reset values: state IDLE; all valid bits 0; `conn_count_o` 0; `conn_data_o` 0; `conn_valid_o` 0; `table_full_o` 0.
- Latency: request sampled at edge E → `conn_valid_o` high in the cycle after edge E+2 when the first probe resolves. Each extra probe adds 1 cycle.
- Worst case (full table): `conn_valid_o` after edge E+1+2^ID_BITS.
- A table write and the count increment take effect on the same edge as the transition to RESP. A back-to-back identical tuple therefore hits.
- Minimum spacing between accepted requests: RESP + DONE + IDLE = 3 cycles after the pulse, given the parser drops valid immediately.
- Reset asserted mid-lookup: immediate return to IDLE; no partial insert survives; any pending response is lost.

## Structure
- Package `nat_pkg` holds:
  - default ID_BITS and KEY_W constants;
  - the FSM state enum;
  - key-field offsets within the 128-bit tuple.
- One sub-module: `nat_tuple_fold` (combinational, parameterised by KEY_W and ID_BITS), which produces the start index.
- Table valid vector, key array, FSM and counter live in `nat_conn_table`.

## Test plan
- **Reset then first request:** tuple with protocol 0x06, all else 0 → hash 0x06. `conn_valid_o` pulses 3 cycles after the request with `conn_data_o` = 0x0006; `conn_count_o` = 1.
- **Repeat same tuple:** → hit, ID 0x0006, `conn_count_o` stays 1, same latency.
- **Collision:** protocol 0x46, dst_port 0x0010 (bits 6 and 12 cancel → hash 6) → entry 6 is occupied, so probe continues; ID 0x0007, latency 4 cycles, count 2.
- **Wrap-around:** preload index 63, then issue a collision at 63 → ID 0x0000.
- **Full table:**
  - Fill all 64 entries → `table_full_o` = 1.
  - A new tuple → `conn_data_o` = 0x8000 after 66 cycles.
  - An existing tuple still hits normally.
- **Stale level and mid-lookup reset:**
  - Hold `tuple_valid_i` high for 10 cycles after the pulse → exactly one response.
  - Assert `reset` during PROBE → outputs return to 0, count 0, and the tuple is not stored.
